debounce_filter: RTL

Input conditioning stage for raw asynchronous digital inputs: synchronizes the pin, rejects pulses shorter than a configurable stability window, and delivers a clean level plus single-cycle edge strobes. It sits directly upstream of the pulse-generation stage: `dout` drives that stage's `din`, and `rise`/`fall` are available to edge-counting consumers. A saturating glitch counter exposes input noise for diagnostics.

---
 rtl/debounce_filter.sv | 86 ++++++++
 1 files changed

// File: rtl/debounce_filter.sv
// Input conditioner: two-flop synchronizer, stability-window filter, edge strobes
// and a saturating count of rejected pulses.
module debounce_filter #(
  parameter int FILTER_LEN = 16,
  parameter int INVERT     = 0,
  parameter int GLITCH_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                glitch_clr,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                  CW         = (FILTER_LEN + 1 > 2) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [CW-1:0]       CNT_LAST   = CW'(FILTER_LEN - 1);
  localparam logic                INV        = (INVERT != 0);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic [1:0]          sync;
  logic                s;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                dout_nxt;
  logic                rise_nxt;
  logic                fall_nxt;
  logic                glitch_evt;
  logic [GLITCH_W-1:0] glitch_nxt;

  // Filter decision: follow s only after it has differed from dout for FILTER_LEN edges.
  always_comb begin
    s          = sync[1] ^ INV;
    cnt_nxt    = cnt;
    dout_nxt   = dout;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_evt = 1'b0;
    if (s != dout) begin
      if (cnt == CNT_LAST) begin
        dout_nxt = s;
        cnt_nxt  = '0;
        rise_nxt = s;
        fall_nxt = ~s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else if (cnt != '0) begin
      cnt_nxt    = '0;
      glitch_evt = 1'b1;
    end else begin
      cnt_nxt = cnt;
    end

    // A clear coinciding with a rejection wins.
    if (glitch_clr) begin
      glitch_nxt = '0;
    end else if (glitch_evt && (glitch_cnt != GLITCH_MAX)) begin
      glitch_nxt = glitch_cnt + GLITCH_W'(1);
    end else begin
      glitch_nxt = glitch_cnt;
    end
  end

  // State registers; dout resets to INVERT so an idle-low pin produces no strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 2'b00;
      cnt        <= '0;
      dout       <= INV;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync       <= {sync[0], din};
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      glitch_cnt <= glitch_nxt;
    end
  end

endmodule
